// File: rtl/serial_rx_engine.sv
// serial_rx_engine
//   Receive side of the full-duplex serial block. Generates the receive serial
//   clock, samples data_rx on its internal falling edge, and assembles words of
//   DATA_W bits (LSB- or MSB-first). One start command receives BURST words
//   back to back.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   Defined:   every frame carries one trailing even-parity bit; parity_err
//              reports the check for each latched word.
//   Undefined: frames are exactly DATA_W bits; parity_err is tied low.
//
// Parameters
//   DATA_W    bits per word (2..64)
//   HALF_DIV  clk cycles per sck_rx half-period (>=1)
//   BURST     words per start command (1..255)
//   LSB_FIRST 1: first bit -> bit 0, 0: first bit -> bit DATA_W-1
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a burst (sampled only when idle)
//   abort        cancel the burst in progress; wins over start
//   data_rx      serial data, changed by the far end on sck_rx rising edge
//   sck_rx       generated serial clock (registered)
//   receive_data last completed word
//   latch_flag   1-cycle pulse when receive_data updates
//   word_cnt     words latched in the current burst
//   busy         burst in progress
//   finish       1-cycle pulse with the last latch of a burst
//   parity_err   parity check result for the word just latched
module serial_rx_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned HALF_DIV  = 1,
  parameter int unsigned BURST     = 1,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              data_rx,
  output logic              sck_rx,
  output logic [DATA_W-1:0] receive_data,
  output logic              latch_flag,
  output logic [7:0]        word_cnt,
  output logic              busy,
  output logic              finish,
  output logic              parity_err
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + 1;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam int unsigned BCNT_W = $clog2(FRAME_W + 1);
  localparam int unsigned HCNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCK_HI,
    SCK_LO
  } state_t;

  state_t              state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                latch_q, latch_d;
  logic                finish_q, finish_d;
  logic                sck_q, sck_d;
  logic                busy_q, busy_d;
  logic                half_done;
  logic [DATA_W-1:0]   shift_in;
`ifdef SERIAL_RX_PARITY_EN
  logic                pacc_q, pacc_d;
  logic                pbit_q, pbit_d;
  logic                perr_q, perr_d;
`endif

  // New bit enters at the end that ends up holding bit 0 (LSB-first) or
  // bit DATA_W-1 (MSB-first) once the whole word has been shifted in.
  assign shift_in = (LSB_FIRST != 0) ? {data_rx, shift_q[DATA_W-1:1]}
                                     : {shift_q[DATA_W-2:0], data_rx};

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    wcnt_d    = wcnt_q;
    latch_d   = 1'b0;
    finish_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    pacc_d    = pacc_q;
    pbit_d    = pbit_q;
    perr_d    = perr_q;
`endif
    half_done = (hcnt_q == HCNT_W'(HALF_DIV - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCK_HI;
          hcnt_d  = '0;
          bcnt_d  = '0;
          wcnt_d  = '0;
`ifdef SERIAL_RX_PARITY_EN
          pacc_d  = 1'b0;
`endif
        end
      end

      SCK_HI: begin
        if (half_done) begin
          // Internal falling edge of sck_rx: sample the bit.
          state_d = SCK_LO;
          hcnt_d  = '0;
          bcnt_d  = bcnt_q + BCNT_W'(1);
`ifdef SERIAL_RX_PARITY_EN
          if (bcnt_q < BCNT_W'(DATA_W)) begin
            shift_d = shift_in;
            pacc_d  = pacc_q ^ data_rx;
          end else begin
            pbit_d  = data_rx;
          end
`else
          shift_d = shift_in;
`endif
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      SCK_LO: begin
        if (half_done) begin
          hcnt_d = '0;
          if (bcnt_q == BCNT_W'(FRAME_W)) begin
            rdata_d = shift_q;
            latch_d = 1'b1;
            wcnt_d  = wcnt_q + 8'd1;
            bcnt_d  = '0;
`ifdef SERIAL_RX_PARITY_EN
            perr_d  = pacc_q ^ pbit_q;
            pacc_d  = 1'b0;
`endif
            if (({1'b0, wcnt_q} + 9'd1) < 9'(BURST)) begin
              state_d = SCK_HI;
            end else begin
              state_d  = IDLE;
              finish_d = 1'b1;
            end
          end else begin
            state_d = SCK_HI;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above: drop the partial word but
    // keep the last completed word and its count.
    if (abort) begin
      state_d  = IDLE;
      rdata_d  = rdata_q;
      wcnt_d   = wcnt_q;
      latch_d  = 1'b0;
      finish_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_d   = perr_q;
`endif
    end

    sck_d  = (state_d == SCK_HI);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      wcnt_q   <= '0;
      latch_q  <= 1'b0;
      finish_q <= 1'b0;
      sck_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      pacc_q   <= 1'b0;
      pbit_q   <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      wcnt_q   <= wcnt_d;
      latch_q  <= latch_d;
      finish_q <= finish_d;
      sck_q    <= sck_d;
      busy_q   <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
      pacc_q   <= pacc_d;
      pbit_q   <= pbit_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign sck_rx       = sck_q;
  assign receive_data = rdata_q;
  assign latch_flag   = latch_q;
  assign word_cnt     = wcnt_q;
  assign busy         = busy_q;
  assign finish       = finish_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/serial_rx_engine.md
# serial_rx_engine

Parametrised successor to the fixed 32-bit serial receive FSM. It generates the receive serial clock `sck_rx`, samples `data_rx`, and assembles words of configurable width, bit order and clock divide. One start command can receive a burst of several words. It sits on the receive side of the full-duplex serial module, between the serial pins and the word-level consumer.

## Interface
- `DATA_W`, 32: bits per word (2..64).
- `HALF_DIV`, 1: `clk` cycles per `sck_rx` half-period (>=1).
- `BURST`, 1: words received per start command (1..255).
- `LSB_FIRST`, 1: 1 = first received bit goes to bit 0; 0 = first received bit goes to bit `DATA_W-1`.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin burst; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the burst in progress.
- `data_rx` in 1: serial data; the far end updates it on the `sck_rx` rising edge.
- `sck_rx` out 1: generated serial clock, registered.
- `receive_data` out `DATA_W`: last completed word, held until the next word completes.
- `latch_flag` out 1: 1-cycle pulse when `receive_data` updates.
- `word_cnt` out 8: words latched in the current burst.
- `busy` out 1: high from the cycle after `start` until `finish`.
- `finish` out 1: 1-cycle pulse at the end of the burst.
- `parity_err` out 1: parity result for the word just latched (see Configuration).

## Operation
- States: IDLE, SCK_HI, SCK_LO.
  - `sck_rx` = 1 exactly when the state is SCK_HI.
- IDLE:
  - `start`=1 → SCK_HI; clear `word_cnt`, bit counter and half-period counter.
- SCK_HI:
  - After `HALF_DIV` cycles → SCK_LO.
  - On the clock edge of this transition, sample `data_rx` into the shift register and increment the bit counter.
- SCK_LO:
  - After `HALF_DIV` cycles, if bits remain in the word → SCK_HI.
  - If the word is complete:
    - Copy the shift register to `receive_data`, pulse `latch_flag`, increment `word_cnt`.
    - If `word_cnt+1 < BURST` → SCK_HI (no gap between words).
    - Otherwise pulse `finish`, drop `busy`, go to IDLE.
- `start` while `busy` is ignored.
- `abort` (any state):
  - Next state is IDLE; `sck_rx` is 0 the next cycle.
  - No `latch_flag` and no `finish` pulse.
  - `receive_data` and `word_cnt` are retained; the partial word is discarded.
- `abort` and `start` asserted together in IDLE: `abort` wins, the block stays idle.
- `rst` has priority over everything:
  - All outputs go to 0, including `receive_data`, `word_cnt` and `parity_err`.
  - State goes to IDLE; counters are cleared.
  - A reset mid-burst produces no pulses.
- Bit order:
  - `LSB_FIRST`=1: bit k of the word maps to `receive_data[k]`.
  - `LSB_FIRST`=0: bit k maps to `receive_data[DATA_W-1-k]`.

## Timing
- Let E0 be the `clk` edge that samples `start`. H = `HALF_DIV`, N = bits per frame (`DATA_W`, or `DATA_W+1` with parity).
- `sck_rx` rises after E0 and busy is high from the cycle after E0.
- Bit k is sampled at edge E(H + 2Hk), i.e. on the internal `sck_rx` falling edge.
- Word w (0-based) latches at edge E(2HN(w+1)).
  - `latch_flag` and the new `receive_data` are visible in the following cycle.
  - The next word's `sck_rx` rises on that same edge.
- `finish` coincides with the final `latch_flag`.
- Defaults (H=1, DATA_W=32, no parity): `latch_flag` is visible in the cycle following E64, sampling edge E64 — 64 cycles after `start` was sampled.
- A new `start` is accepted from the cycle after `finish`.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- Defined:
  - Each frame carries one extra bit after the data bits: even parity over the data bits.
  - `parity_err` is updated together with `latch_flag`: 1 if the parity mismatches.
  - `receive_data` is latched regardless of the parity result.
- Undefined:
  - Frames are exactly `DATA_W` bits.
  - `parity_err` is tied to 0.

## Test plan
- Reset:
  - Assert `rst` for 2 cycles mid-burst → `sck_rx`, `busy`, `latch_flag`, `finish`, `word_cnt` and `receive_data` all 0 the next cycle.
  - No pulse follows the reset.
- Default single word:
  - Far end shifts 32'd1456478547 LSB-first on each `sck_rx` rise.
  - → `receive_data`=32'd1456478547, visible in the cycle following E64.
  - One `latch_flag` pulse and one `finish` pulse; 64 `sck_rx` edges.
- MSB-first with divide:
  - `DATA_W`=8, `LSB_FIRST`=0, `HALF_DIV`=3; stream 8'hA5.
  - → `receive_data`=8'hA5 and `sck_rx` high for 3 cycles per bit; latch at E48.
- Burst:
  - `BURST`=3, `DATA_W`=16; stream 16'h1234, 16'hBEEF, 16'h0001.
  - → three `latch_flag` pulses 32 cycles apart, `word_cnt` 1, 2, 3.
  - `finish` with the third pulse; `start` during the burst is ignored.
- Abort:
  - `abort` after 10 bits of word 1 of a `BURST`=2 run.
  - → `sck_rx` is 0 the next cycle; no `latch_flag`, no `finish`.
  - `receive_data` keeps word 0 and `word_cnt`=1.
- Parity (`SERIAL_RX_PARITY_EN` defined):
  - `DATA_W`=8, data 8'h03 with parity bit 0 → `parity_err`=0.
  - Same data with parity bit 1 → `parity_err`=1 and `receive_data`=8'h03.
